ring_counter_multi: RTL

//  Parametrised successor to our 4-bit ring counter. Generates ring (one-hot),
//  one-cold ring or Johnson sequences, with a direction control, a programmable

---
 rtl/ring_counter_multi_if.sv | 29 ++
 rtl/ring_counter_multi.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ring_counter_multi_if.sv
// Control and status bundle for ring_counter_multi: count controls in, counter state out.
// Inputs are level-sampled on every rising clock; load is a one-cycle strobe with no back-pressure.
interface ring_counter_multi_if #(
   parameter int WIDTH = 4,
   parameter int DIV_W = 16
);
   logic             en;
   logic [1:0]       mode;
   logic             dir;
   logic [DIV_W-1:0] div;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             wrap;
   logic             illegal;
   logic [WIDTH-1:0] io_oeb;
   logic [1:0]       mode_state;
   logic [DIV_W-1:0] cnt;

   modport master (
      output en, mode, dir, div, load, load_val,
      input  q, wrap, illegal, io_oeb, mode_state, cnt
   );

   modport slave (
      input  en, mode, dir, div, load, load_val,
      output q, wrap, illegal, io_oeb, mode_state, cnt
   );
endinterface

// File: rtl/ring_counter_multi.sv
// Ring / one-cold / Johnson counter with direction, prescaler, parallel load and
// self-correction of illegal states back to the mode seed.
module ring_counter_multi #(
   parameter int WIDTH = 4,
   parameter int DIV_W = 16
) (
   input logic                clock,
   input logic                resetb,
   ring_counter_multi_if.slave bus
);
   localparam logic [1:0] MODE_RING    = 2'b00;
   localparam logic [1:0] MODE_JOHNSON = 2'b01;
   localparam logic [1:0] MODE_COLD    = 2'b10;
   localparam logic [1:0] MODE_HOLD    = 2'b11;

   logic [WIDTH-1:0] q_r, q_n;
   logic [1:0]       mode_r, mode_n;
   logic [DIV_W-1:0] cnt_r, cnt_n;
   logic             wrap_r, wrap_n;
   logic             illegal_r, illegal_n;
   logic [WIDTH-1:0] stepped;

   function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
      logic [WIDTH-1:0] one_hot;
      one_hot = '0;
      one_hot[WIDTH-1] = 1'b1;
      case (m)
         MODE_JOHNSON: seed_of = '0;
         MODE_COLD:    seed_of = ~one_hot;
         default:      seed_of = one_hot;
      endcase
   endfunction

   function automatic logic is_legal(input logic [1:0] m, input logic [WIDTH-1:0] v);
      int ones;
      int edges;
      ones  = 0;
      edges = 0;
      for (int i = 0; i < WIDTH; i++) ones = ones + {31'b0, v[i]};
      for (int i = 0; i < WIDTH - 1; i++) edges = edges + {31'b0, v[i] ^ v[i+1]};
      case (m)
         MODE_RING:    is_legal = (ones == 1);
         MODE_JOHNSON: is_legal = (edges <= 1);
         MODE_COLD:    is_legal = (ones == WIDTH - 1);
         default:      is_legal = 1'b1;
      endcase
   endfunction

   // Johnson inverts the bit wrapping around; the rings rotate it unchanged.
   function automatic logic [WIDTH-1:0] step_of(input logic [1:0] m, input logic d,
                                                input logic [WIDTH-1:0] v);
      logic fill;
      if (d) begin
         fill    = (m == MODE_JOHNSON) ? ~v[WIDTH-1] : v[WIDTH-1];
         step_of = {v[WIDTH-2:0], fill};
      end else begin
         fill    = (m == MODE_JOHNSON) ? ~v[0] : v[0];
         step_of = {fill, v[WIDTH-1:1]};
      end
   endfunction

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         q_r       <= seed_of(MODE_RING);
         mode_r    <= MODE_RING;
         cnt_r     <= '0;
         wrap_r    <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         q_r       <= q_n;
         mode_r    <= mode_n;
         cnt_r     <= cnt_n;
         wrap_r    <= wrap_n;
         illegal_r <= illegal_n;
      end
   end

   // Priority: load, then mode change, then illegal-state repair, then prescaled step.
   always_comb begin
      q_n       = q_r;
      mode_n    = mode_r;
      cnt_n     = cnt_r;
      wrap_n    = 1'b0;
      illegal_n = 1'b0;
      stepped   = step_of(mode_r, bus.dir, q_r);
      if (bus.load) begin
         cnt_n = '0;
         if (is_legal(mode_r, bus.load_val)) begin
            q_n = bus.load_val;
         end else begin
            q_n       = seed_of(mode_r);
            illegal_n = 1'b1;
         end
      end else if (bus.mode != mode_r) begin
         mode_n = bus.mode;
         q_n    = seed_of(bus.mode);
         cnt_n  = '0;
      end else if (mode_r != MODE_HOLD && !is_legal(mode_r, q_r)) begin
         q_n       = seed_of(mode_r);
         illegal_n = 1'b1;
      end else if (bus.en && mode_r != MODE_HOLD) begin
         if (cnt_r == bus.div) begin
            cnt_n  = '0;
            q_n    = stepped;
            wrap_n = (stepped == seed_of(mode_r));
         end else begin
            cnt_n = cnt_r + DIV_W'(1);
         end
      end
   end

   always_comb begin
      bus.q          = q_r;
      bus.wrap       = wrap_r;
      bus.illegal    = illegal_r;
      bus.io_oeb     = '0;
      bus.mode_state = mode_r;
      bus.cnt        = cnt_r;
   end
endmodule
